// File: rtl/dac_spi_tx.sv
// Serial driver for a TLC5615-class DAC: 12-bit frames ({sample,2'b00}, MSB first), 25*CLK_DIV cycles with cs_n low, then GAP_CYC quiet cycles.
// Requests arriving while busy are dropped and are counted only when DAC_OVERRUN_CNT_EN is defined.
module dac_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] wave_data,
  input  logic       sample_en,
  output logic       busy,
  output logic       frame_done,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic [7:0] overrun_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_bit;
  logic [11:0] r_sreg;
  logic        r_busy;
  logic        r_done;
  logic        r_cs_n;
  logic        r_sclk;

  logic w_div_end;
  logic w_gap_end;

  assign w_div_end = (r_cnt == DIV_LAST);
  assign w_gap_end = (r_cnt == GAP_LAST);

  // Serial data is the shift register MSB; it empties to zero after 12 shifts, so din idles low.
  assign dac_din    = r_sreg[11];
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign dac_cs_n   = r_cs_n;
  assign dac_sclk   = r_sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_bit   <= 4'd0;
      r_sreg  <= 12'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_en) begin
            r_sreg  <= {wave_data, 2'b00};
            r_state <= ST_SETUP;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= 8'd0;
            r_bit   <= 4'd0;
          end
        end
        ST_SETUP: begin
          if (w_div_end) begin
            r_cnt   <= 8'd0;
            r_state <= ST_SHIFT_HI;
            r_sclk  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_SHIFT_HI: begin
          // Advance data on the falling edge so din is stable across the whole high phase.
          if (w_div_end) begin
            r_cnt   <= 8'd0;
            r_state <= ST_SHIFT_LO;
            r_sclk  <= 1'b0;
            r_sreg  <= {r_sreg[10:0], 1'b0};
            r_bit   <= r_bit + 4'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_SHIFT_LO: begin
          if (w_div_end) begin
            r_cnt <= 8'd0;
            if (r_bit < 4'd12) begin
              r_state <= ST_SHIFT_HI;
              r_sclk  <= 1'b1;
            end else begin
              r_state <= ST_GAP;
              r_cs_n  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (w_gap_end) begin
            r_cnt   <= 8'd0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 8'd0;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DAC_OVERRUN_CNT_EN
  logic [7:0] r_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 8'd0;
    end else if (sample_en && r_busy && (r_ovr != 8'hFF)) begin
      r_ovr <= r_ovr + 8'd1;
    end
  end

  assign overrun_cnt = r_ovr;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule
